// File: rtl/pc_seq_pkg.sv
// Shared encodings for the fetch-stage PC sequencer and its return-address stack.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        JMP_SEQ = 2'd0,
        JMP_J   = 2'd1,
        JMP_JR  = 2'd2,
        JMP_JAL = 2'd3
    } jmp_e;

    localparam int unsigned PC_INC = 32'd4;

endpackage

// File: rtl/ras_stack.sv
// Return-address stack: circular buffer with a top pointer and a count that
// saturates at RAS_DEPTH, so a push onto a full stack overwrites the oldest entry.
module ras_stack
    import pc_seq_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         i_push,
    input  logic                         i_pop,
    input  logic [WIDTH-1:0]             i_push_data,
    output logic [WIDTH-1:0]             o_top,
    output logic [$clog2(RAS_DEPTH):0]   o_count,
    output logic                         o_empty
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [RAS_DEPTH];
    logic [PTR_W-1:0] r_ptr;
    logic [CNT_W-1:0] r_count;
    logic [PTR_W-1:0] w_ptr_inc;
    logic [PTR_W-1:0] w_ptr_dec;
    logic             w_full;

    assign w_ptr_inc = r_ptr + PTR_W'(1);
    assign w_ptr_dec = r_ptr - PTR_W'(1);
    assign w_full    = (r_count == CNT_W'(RAS_DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_top     = o_empty ? '0 : r_mem[r_ptr];
    assign o_count   = r_count;

    // Pointer and count; the pointer wraps naturally since depth is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr   <= '1;
            r_count <= '0;
        end else if (i_push) begin
            r_ptr   <= w_ptr_inc;
            r_count <= w_full ? r_count : r_count + CNT_W'(1);
        end else if (i_pop && !o_empty) begin
            r_ptr   <= w_ptr_dec;
            r_count <= r_count - CNT_W'(1);
        end else begin
            r_ptr   <= r_ptr;
            r_count <= r_count;
        end
    end

    // Entry storage; cleared on reset so no stale address is ever observable.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < RAS_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_push) begin
            r_mem[w_ptr_inc] <= i_push_data;
        end else begin
            r_mem <= r_mem;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage next-PC selection with stall hold and jr return-address checking.
// Optional exception entry (exc/epc ports) is enabled by defining PC_SEQ_EXC_EN.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter int               RAS_DEPTH    = 4,
    parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(32'h80)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_stall,
    input  logic                       i_branch,
    input  logic                       i_zero,
    input  logic [1:0]                 i_jmp,
    input  logic [WIDTH-1:0]           i_imm,
    input  logic [WIDTH-1:0]           i_ra,
    input  logic [25:0]                i_jmp_inst,
    output logic [WIDTH-1:0]           o_pc,
    output logic [WIDTH-1:0]           o_pc_plus4,
    output logic [WIDTH-1:0]           o_ras_top,
    output logic [$clog2(RAS_DEPTH):0] o_ras_count,
    output logic                       o_ras_mispredict,
    output logic                       o_ras_underflow
`ifdef PC_SEQ_EXC_EN
    ,
    input  logic                       i_exc,
    output logic [WIDTH-1:0]           o_epc
`endif
);

    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_pc_plus4;
    logic             r_mispredict;
    logic             r_underflow;

    jmp_e             w_jmp;
    logic             w_exc;
    logic [WIDTH-1:0] w_br_target;
    logic [WIDTH-1:0] w_j_target;
    logic [WIDTH-1:0] w_pc_next;
    logic             w_push;
    logic             w_pop;
    logic             w_mispredict_next;
    logic             w_underflow_next;
    logic [WIDTH-1:0] w_ras_top;
    logic             w_ras_empty;

`ifdef PC_SEQ_EXC_EN
    logic [WIDTH-1:0] r_epc;
    assign w_exc = i_exc;
    assign o_epc = r_epc;

    // Capture the faulting fetch address on exception entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_epc <= '0;
        end else if (w_exc) begin
            r_epc <= r_pc;
        end else begin
            r_epc <= r_epc;
        end
    end
`else
    assign w_exc = 1'b0;
`endif

    assign w_jmp       = jmp_e'(i_jmp);
    assign w_br_target = r_pc_plus4 + (i_imm << 2);
    assign w_j_target  = {r_pc_plus4[WIDTH-1:28], i_jmp_inst, 2'b00};

    // Next-PC priority: exception, stall, jump kinds, taken branch, sequential.
    always_comb begin
        w_pc_next         = r_pc_plus4;
        w_push            = 1'b0;
        w_pop             = 1'b0;
        w_mispredict_next = 1'b0;
        w_underflow_next  = 1'b0;
        if (w_exc) begin
            w_pc_next = EXC_VECTOR;
        end else if (i_stall) begin
            w_pc_next = r_pc;
        end else begin
            case (w_jmp)
                JMP_J: begin
                    w_pc_next = w_j_target;
                end
                JMP_JAL: begin
                    w_pc_next = w_j_target;
                    w_push    = 1'b1;
                end
                JMP_JR: begin
                    // The RAS only predicts; the architectural target is always ra.
                    w_pc_next = i_ra;
                    if (w_ras_empty) begin
                        w_underflow_next = 1'b1;
                    end else begin
                        w_pop             = 1'b1;
                        w_mispredict_next = (i_ra != w_ras_top);
                    end
                end
                default: begin
                    if (i_branch && i_zero) begin
                        w_pc_next = w_br_target;
                    end else begin
                        w_pc_next = r_pc_plus4;
                    end
                end
            endcase
        end
    end

    // PC and PC+4 are registered together so pc_plus4 never lags pc.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc       <= RESET_VECTOR;
            r_pc_plus4 <= RESET_VECTOR + WIDTH'(PC_INC);
        end else begin
            r_pc       <= w_pc_next;
            r_pc_plus4 <= w_pc_next + WIDTH'(PC_INC);
        end
    end

    // Single-cycle jr outcome flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mispredict <= 1'b0;
            r_underflow  <= 1'b0;
        end else begin
            r_mispredict <= w_mispredict_next;
            r_underflow  <= w_underflow_next;
        end
    end

    ras_stack #(
        .WIDTH     (WIDTH),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_push),
        .i_pop       (w_pop),
        .i_push_data (r_pc_plus4),
        .o_top       (w_ras_top),
        .o_count     (o_ras_count),
        .o_empty     (w_ras_empty)
    );

    assign o_pc             = r_pc;
    assign o_pc_plus4       = r_pc_plus4;
    assign o_ras_top        = w_ras_top;
    assign o_ras_mispredict = r_mispredict;
    assign o_ras_underflow  = r_underflow;

endmodule
